// File: rtl/hazard_if.sv
// Pipeline-side bundle for hazard_controller: hazard inputs from R/X/M/W and
// the stage enable / bubble controls plus status going back.
interface hazard_if;
  logic [4:0]  r_rs, r_rt;
  logic        r_use_rs, r_use_rt;
  logic [4:0]  x_rd, m_rd, w_rd;
  logic        x_we, m_we, w_we;
  logic        x_load, x_branch_taken;
  logic        m_req, m_ready;
  logic        e_f, e_r, e_x, e_m, e_w;
  logic        bub_r, bub_x, bub_w;
  logic        mem_err;
  logic [31:0] perf_stall, perf_data, perf_flush;

  modport master (
    output r_rs, r_rt, r_use_rs, r_use_rt, x_rd, m_rd, w_rd, x_we, m_we, w_we,
           x_load, x_branch_taken, m_req, m_ready,
    input  e_f, e_r, e_x, e_m, e_w, bub_r, bub_x, bub_w, mem_err,
           perf_stall, perf_data, perf_flush
  );

  modport slave (
    input  r_rs, r_rt, r_use_rs, r_use_rt, x_rd, m_rd, w_rd, x_we, m_we, w_we,
           x_load, x_branch_taken, m_req, m_ready,
    output e_f, e_r, e_x, e_m, e_w, bub_r, bub_x, bub_w, mem_err,
           perf_stall, perf_data, perf_flush
  );
endinterface

// File: rtl/hazard_controller.sv
// hazard_controller: stage enables and NOP-insert controls for the F/R/X/M/W
// pipeline. Handles RAW stalls, a two-cycle taken-branch flush, freezes on
// data-memory wait states and a sticky memory watchdog.
// Optional macro HAZARD_PERF_EN builds the 32-bit performance counters;
// without it the perf_* outputs are tied to zero.
module hazard_controller #(
  parameter bit          FORWARDING  = 1'b0,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic     clk,
  input  logic     rst,
  hazard_if.slave  hif
);
  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [16:0] TIMEOUT = 17'(MEM_TIMEOUT);

  state_t      state_q, state_d;
  logic [15:0] wd_q, wd_d;
  logic        mem_err_q, mem_err_d;

  logic        hit_x, hit_m, hit_w, data_hz, mem_stall;
  logic        stall_cyc, data_cyc, flush_evt;
  logic [16:0] wd_inc;

  function automatic logic hit(logic [4:0] s, logic u, logic [4:0] rd, logic we);
    return u & we & (rd != 5'd0) & (rd == s);
  endfunction

  // Hazard detection against the instructions ahead of R.
  always_comb begin
    hit_x     = hit(hif.r_rs, hif.r_use_rs, hif.x_rd, hif.x_we) |
                hit(hif.r_rt, hif.r_use_rt, hif.x_rd, hif.x_we);
    hit_m     = hit(hif.r_rs, hif.r_use_rs, hif.m_rd, hif.m_we) |
                hit(hif.r_rt, hif.r_use_rt, hif.m_rd, hif.m_we);
    hit_w     = hit(hif.r_rs, hif.r_use_rs, hif.w_rd, hif.w_we) |
                hit(hif.r_rt, hif.r_use_rt, hif.w_rd, hif.w_we);
    data_hz   = FORWARDING ? (hit_x & hif.x_load) : (hit_x | hit_m | hit_w);
    mem_stall = hif.m_req & ~hif.m_ready;
  end

  // Prioritised control decode; a branch squashes any concurrent hazard.
  always_comb begin
    hif.e_f   = 1'b1;
    hif.e_r   = 1'b1;
    hif.e_x   = 1'b1;
    hif.e_m   = 1'b1;
    hif.e_w   = 1'b1;
    hif.bub_r = 1'b0;
    hif.bub_x = 1'b0;
    hif.bub_w = 1'b0;
    stall_cyc = 1'b0;
    data_cyc  = 1'b0;
    flush_evt = 1'b0;
    state_d   = RUN;
    if (rst) begin
      hif.e_f = 1'b0;
      hif.e_r = 1'b0;
      hif.e_x = 1'b0;
      hif.e_m = 1'b0;
      hif.e_w = 1'b0;
    end else if (mem_stall) begin
      // Freeze everything upstream of W; W drains as a bubble.
      hif.e_f   = 1'b0;
      hif.e_r   = 1'b0;
      hif.e_x   = 1'b0;
      hif.e_m   = 1'b0;
      hif.bub_w = 1'b1;
      stall_cyc = 1'b1;
      state_d   = state_q;
    end else if (hif.x_branch_taken) begin
      hif.bub_r = 1'b1;
      hif.bub_x = 1'b1;
      flush_evt = 1'b1;
      state_d   = FLUSH;
    end else if (state_q == FLUSH) begin
      // Second bubble: the synchronous IMEM word fetched pre-redirect is stale.
      hif.bub_r = 1'b1;
    end else if (data_hz) begin
      hif.e_f   = 1'b0;
      hif.e_r   = 1'b0;
      hif.bub_x = 1'b1;
      stall_cyc = 1'b1;
      data_cyc  = 1'b1;
    end
  end

  // Watchdog: counts consecutive stall cycles, saturating so it cannot wrap.
  always_comb begin
    wd_inc    = {1'b0, wd_q} + 17'd1;
    wd_d      = 16'd0;
    mem_err_d = mem_err_q;
    if (mem_stall) begin
      wd_d = (wd_q == 16'hFFFF) ? wd_q : wd_inc[15:0];
      if (wd_inc >= TIMEOUT) mem_err_d = 1'b1;
    end
  end

  // State, watchdog and error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      wd_q      <= 16'd0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign hif.mem_err = mem_err_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_data_q,  perf_data_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Free-running event counters, wrapping modulo 2^32.
  always_comb begin
    perf_stall_d = perf_stall_q + {31'd0, stall_cyc};
    perf_data_d  = perf_data_q  + {31'd0, data_cyc};
    perf_flush_d = perf_flush_q + {31'd0, flush_evt};
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= 32'd0;
      perf_data_q  <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_data_q  <= perf_data_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign hif.perf_stall = perf_stall_q;
  assign hif.perf_data  = perf_data_q;
  assign hif.perf_flush = perf_flush_q;
`else
  logic unused_perf;
  assign unused_perf    = stall_cyc ^ data_cyc ^ flush_evt;
  assign hif.perf_stall = 32'd0;
  assign hif.perf_data  = 32'd0;
  assign hif.perf_flush = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: one instance without and one with forwarding,
// both MEM_TIMEOUT=4, fed identical stimulus (directed then random) and
// compared every cycle against a rule-level reference model.
module tb_hazard_controller;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0] r_rs, r_rt, x_rd, m_rd, w_rd;
  logic       r_use_rs, r_use_rt, x_we, m_we, w_we, x_load, x_branch_taken, m_req, m_ready;

  hazard_if if0();
  hazard_if if1();

  assign if0.r_rs = r_rs;         assign if1.r_rs = r_rs;
  assign if0.r_rt = r_rt;         assign if1.r_rt = r_rt;
  assign if0.r_use_rs = r_use_rs; assign if1.r_use_rs = r_use_rs;
  assign if0.r_use_rt = r_use_rt; assign if1.r_use_rt = r_use_rt;
  assign if0.x_rd = x_rd;         assign if1.x_rd = x_rd;
  assign if0.m_rd = m_rd;         assign if1.m_rd = m_rd;
  assign if0.w_rd = w_rd;         assign if1.w_rd = w_rd;
  assign if0.x_we = x_we;         assign if1.x_we = x_we;
  assign if0.m_we = m_we;         assign if1.m_we = m_we;
  assign if0.w_we = w_we;         assign if1.w_we = w_we;
  assign if0.x_load = x_load;     assign if1.x_load = x_load;
  assign if0.x_branch_taken = x_branch_taken;
  assign if1.x_branch_taken = x_branch_taken;
  assign if0.m_req = m_req;       assign if1.m_req = m_req;
  assign if0.m_ready = m_ready;   assign if1.m_ready = m_ready;

  hazard_controller #(.FORWARDING(1'b0), .MEM_TIMEOUT(TO)) u_dut0 (.clk(clk), .rst(rst), .hif(if0));
  hazard_controller #(.FORWARDING(1'b1), .MEM_TIMEOUT(TO)) u_dut1 (.clk(clk), .rst(rst), .hif(if1));

  // {e_f,e_r,e_x,e_m,e_w,bub_r,bub_x,bub_w}
  logic [7:0] ctl [2];
  assign ctl[0] = {if0.e_f, if0.e_r, if0.e_x, if0.e_m, if0.e_w, if0.bub_r, if0.bub_x, if0.bub_w};
  assign ctl[1] = {if1.e_f, if1.e_r, if1.e_x, if1.e_m, if1.e_w, if1.bub_r, if1.bub_x, if1.bub_w};

  localparam logic [7:0] C_RST   = 8'b00000_000;
  localparam logic [7:0] C_MEM   = 8'b00001_001;
  localparam logic [7:0] C_BR    = 8'b11111_110;
  localparam logic [7:0] C_FLUSH = 8'b11111_100;
  localparam logic [7:0] C_HZ    = 8'b00111_010;
  localparam logic [7:0] C_RUN   = 8'b11111_000;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state: pending flush, consecutive-stall count, error flag, event counts.
  bit          mdl_flush;
  int unsigned mdl_wait;
  bit          mdl_err;
  logic [31:0] mdl_stall [2];
  logic [31:0] mdl_data  [2];
  logic [31:0] mdl_flushes;

  function automatic bit src_hits(logic [4:0] rd, logic we);
    return we && rd != 0 &&
           ((r_use_rs && r_rs == rd) || (r_use_rt && r_rt == rd));
  endfunction

  function automatic bit hazard(int fw);
    if (fw == 0) return src_hits(x_rd, x_we) || src_hits(m_rd, m_we) || src_hits(w_rd, w_we);
    return src_hits(x_rd, x_we) && x_load;
  endfunction

  function automatic logic [7:0] expect_ctl(int fw);
    bit wait_mem;
    wait_mem = m_req && !m_ready;
    if (rst)            return C_RST;
    if (wait_mem)       return C_MEM;
    if (x_branch_taken) return C_BR;
    if (mdl_flush)      return C_FLUSH;
    if (hazard(fw))     return C_HZ;
    return C_RUN;
  endfunction

  // One clock: check combinational outputs (plus optional literal), cross the edge, advance model.
  task automatic step(input string tag, input bit lit_en, input int lit_fw, input logic [7:0] lit);
    bit wait_mem, hz_stall [2];
    #1;
    for (int f = 0; f < 2; f++) chk($sformatf("%s_ctl_fw%0d", tag, f), 32'(ctl[f]), 32'(expect_ctl(f)));
    chk({tag, "_err0"}, 32'(if0.mem_err), 32'(mdl_err));
    chk({tag, "_err1"}, 32'(if1.mem_err), 32'(mdl_err));
`ifdef HAZARD_PERF_EN
    chk({tag, "_pstall0"}, if0.perf_stall, mdl_stall[0]);
    chk({tag, "_pdata0"},  if0.perf_data,  mdl_data[0]);
    chk({tag, "_pstall1"}, if1.perf_stall, mdl_stall[1]);
    chk({tag, "_pdata1"},  if1.perf_data,  mdl_data[1]);
    chk({tag, "_pflush"},  if0.perf_flush, mdl_flushes);
`else
    chk({tag, "_perf0"}, if0.perf_stall | if0.perf_data | if0.perf_flush, 32'd0);
`endif
    if (lit_en) chk({tag, "_lit"}, 32'(ctl[lit_fw]), 32'(lit));
    wait_mem = m_req && !m_ready;
    for (int f = 0; f < 2; f++) hz_stall[f] = !wait_mem && !x_branch_taken && !mdl_flush && hazard(f);
    @(posedge clk);
    #1;
    if (rst) begin
      mdl_flush = 0; mdl_wait = 0; mdl_err = 0; mdl_flushes = 0;
      for (int f = 0; f < 2; f++) begin mdl_stall[f] = 0; mdl_data[f] = 0; end
    end else begin
      for (int f = 0; f < 2; f++) begin
        if (wait_mem || hz_stall[f]) mdl_stall[f] = mdl_stall[f] + 1;
        if (hz_stall[f])             mdl_data[f]  = mdl_data[f] + 1;
      end
      if (!wait_mem && x_branch_taken) mdl_flushes = mdl_flushes + 1;
      if (wait_mem) begin
        if (mdl_wait < 65535) mdl_wait++;
        if (mdl_wait >= TO) mdl_err = 1;
      end else begin
        mdl_wait  = 0;
        mdl_flush = x_branch_taken;
      end
    end
  endtask

  task automatic idle();
    rst = 0; r_rs = 0; r_rt = 0; r_use_rs = 0; r_use_rt = 0;
    x_rd = 0; m_rd = 0; w_rd = 0; x_we = 0; m_we = 0; w_we = 0;
    x_load = 0; x_branch_taken = 0; m_req = 0; m_ready = 0;
  endtask

  initial begin
    idle();
    mdl_flush = 0; mdl_wait = 0; mdl_err = 0; mdl_flushes = 0;
    mdl_stall[0] = 0; mdl_stall[1] = 0; mdl_data[0] = 0; mdl_data[1] = 0;

    rst = 1;
    step("reset", 1, 0, C_RST);
    chk("reset_err", 32'(if0.mem_err), 32'd0);
    idle();
    step("run", 1, 1, C_RUN);

    // Load-use with forwarding: one stall, then clear as the load reaches M.
    r_rs = 5; r_use_rs = 1; x_rd = 5; x_we = 1; x_load = 1;
    step("lduse", 1, 1, C_HZ);
    x_rd = 0; x_we = 0; x_load = 0; m_rd = 5; m_we = 1;
    step("lduse_clr", 1, 1, C_RUN);
    idle();

    // No forwarding: RAW against W stalls; register 0 never does.
    r_rt = 7; r_use_rt = 1; w_rd = 7; w_we = 1;
    step("raw_w", 1, 0, C_HZ);
    r_rt = 0; w_rd = 0;
    step("raw_r0", 1, 0, C_RUN);
    idle();

    // Single taken branch: two bubble cycles.
    x_branch_taken = 1;
    step("br_n0", 1, 0, C_BR);
    x_branch_taken = 0;
    step("br_n1", 1, 0, C_FLUSH);
    step("br_n2", 1, 0, C_RUN);
`ifdef HAZARD_PERF_EN
    chk("br_pflush", if0.perf_flush, 32'd1);
`endif

    // Branch with concurrent hazard: branch wins.
    x_branch_taken = 1; r_rs = 3; r_use_rs = 1; x_rd = 3; x_we = 1; x_load = 1;
    step("br_hz", 1, 1, C_BR);
    idle();
    step("br_hz_fl", 1, 1, C_FLUSH);

    // Branch frozen by a 3-cycle memory stall, then flushes exactly once.
    x_branch_taken = 1; m_req = 1; m_ready = 0;
    for (int i = 0; i < 3; i++) step("brmem_frz", 1, 0, C_MEM);
    m_ready = 1;
    step("brmem_n0", 1, 0, C_BR);
    idle();
    step("brmem_n1", 1, 0, C_FLUSH);
    step("brmem_n2", 1, 0, C_RUN);

    // Pending FLUSH survives a stall.
    x_branch_taken = 1;
    step("flmem_br", 1, 0, C_BR);
    x_branch_taken = 0; m_req = 1;
    step("flmem_frz0", 1, 0, C_MEM);
    step("flmem_frz1", 1, 0, C_MEM);
    idle();
    step("flmem_fl", 1, 0, C_FLUSH);

    // Watchdog: rises on the 4th stall edge, sticky until reset.
    m_req = 1; m_ready = 0;
    for (int i = 0; i < 3; i++) step("wd", 0, 0, 8'd0);
    chk("wd_pre", 32'(if0.mem_err), 32'd0);
    step("wd4", 0, 0, 8'd0);
    chk("wd_set", 32'(if0.mem_err), 32'd1);
    m_ready = 1;
    step("wd_rel", 1, 0, C_RUN);
    chk("wd_sticky", 32'(if1.mem_err), 32'd1);
    rst = 1;
    step("wd_rst", 1, 0, C_RST);
    chk("wd_clr", 32'(if0.mem_err), 32'd0);
    idle();

    // Reset during FLUSH: no stale bubble afterwards.
    x_branch_taken = 1;
    step("rstfl_br", 1, 0, C_BR);
    x_branch_taken = 0; rst = 1;
    step("rstfl_rst", 1, 0, C_RST);
    rst = 0;
    step("rstfl_run", 1, 0, C_RUN);

    // Random traffic with small register numbers to provoke hits.
    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(0, 99) == 0);
      r_rs           = 5'($urandom_range(0, 3));
      r_rt           = 5'($urandom_range(0, 3));
      r_use_rs       = 1'($urandom);
      r_use_rt       = 1'($urandom);
      x_rd           = 5'($urandom_range(0, 3));
      m_rd           = 5'($urandom_range(0, 3));
      w_rd           = 5'($urandom_range(0, 3));
      x_we           = 1'($urandom);
      m_we           = 1'($urandom);
      w_we           = 1'($urandom);
      x_load         = 1'($urandom);
      x_branch_taken = ($urandom_range(0, 7) == 0);
      m_req          = ($urandom_range(0, 2) == 0);
      m_ready        = 1'($urandom);
      step("rnd", 0, 0, 8'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_controller.md
# hazard_controller

Stage-enable and bubble sequencer for the five-stage F/R/X/M/W pipeline. It replaces the always-on stage enables with real interlocking: RAW data-hazard stalls, a two-cycle branch-redirect flush, and freezes on data-memory wait states. A memory watchdog raises a sticky error flag. It sits beside the pipeline registers and drives their enable and NOP-insert controls every cycle.

## Interface
- FORWARDING, 0: 0 = no bypass network, stall on any RAW hit in X/M/W; 1 = bypass present, stall only on load-use in X
- MEM_TIMEOUT, 255: consecutive memory-wait cycles before `mem_err` sets (1..65535)

- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- r_rs, r_rt  in  5  source register numbers of the instruction in R
- r_use_rs, r_use_rt  in  1  source actually read
- x_rd, m_rd, w_rd  in  5  destination register of the instruction in X / M / W
- x_we, m_we, w_we  in  1  that instruction writes `*_rd`
- x_load  in  1  instruction in X is a load
- x_branch_taken  in  1  branch in X resolved taken; F is redirected this cycle
- m_req, m_ready  in  1  data-memory request from M; memory accepts or returns this cycle
- e_f, e_r, e_x, e_m, e_w  out  1  load enable of the F/R/X/M/W pipeline latch
- bub_r, bub_x, bub_w  out  1  load a NOP instead of the upstream value into the R/X/W latch (only meaningful with the matching enable = 1)
- mem_err  out  1  sticky watchdog error
- perf_stall, perf_data, perf_flush  out  32  performance counters (see Configuration)

## Operation
- hit(s,u,rd,we) = u & we & (rd != 0) & (rd == s). A source hits a stage if hit() is true for r_rs or r_rt.
- data_hz:
  - FORWARDING=0: any source hits X, M, or W.
  - FORWARDING=1: any source hits X, and x_load = 1.
- mem_stall = m_req & ~m_ready.
- State register: RUN or FLUSH. Controls are decoded combinationally each cycle, highest priority first:
  1. rst: all e_* = 0, all bub_* = 0.
  2. mem_stall: e_f=e_r=e_x=e_m=0, e_w=1, bub_w=1. State held.
  3. x_branch_taken: all e_*=1, bub_r=1, bub_x=1. Next state FLUSH.
  4. state FLUSH: all e_*=1, bub_r=1, which discards the stale fetch word from synchronous IMEM. Next state RUN.
  5. data_hz: e_f=e_r=0, e_x=e_m=e_w=1, bub_x=1.
  6. Otherwise all e_*=1, all bub_*=0.
- Boundary rules:
  - A branch frozen in X by mem_stall flushes on the first cycle mem_stall drops.
  - A pending FLUSH survives any number of mem_stall cycles.
  - Branch and data_hz in the same cycle: the branch wins and the hazard is dropped, because its instruction is squashed.
  - A hazard on register 0 never stalls.
- Watchdog: a 16-bit counter increments on each mem_stall cycle and clears on any non-stall cycle.
  - On reaching MEM_TIMEOUT, mem_err sets and stays set until rst.
  - The pipeline keeps waiting; it does not abort.

## Timing
- All outputs are combinational from current inputs and state. They take effect at the next rising clk edge.
- State, watchdog, mem_err and counters update on the rising edge.
- Reset values: state RUN, watchdog 0, mem_err 0, perf_* 0.
- Load-use with FORWARDING=1 costs exactly 1 stall cycle. The load moves to M, so the hit clears.
- Taken branch costs 2 bubble cycles: the resolve cycle plus FLUSH.
- mem_err rises on the edge that ends the MEM_TIMEOUT-th consecutive stall cycle.
- rst asserted mid-FLUSH or mid-stall returns to RUN on the next edge.

## Configuration
- HAZARD_PERF_EN defined:
  - perf_stall counts cycles with mem_stall or data_hz stalling F.
  - perf_data counts data_hz stall cycles.
  - perf_flush counts taken-branch events (priority 3).
  - All counters are 32 bits, wrap modulo 2^32, and are cleared by rst.
- HAZARD_PERF_EN undefined: the counter registers are not built, and the perf_* ports are tied to 0.

## Test plan
- FORWARDING=1, X holds a load with x_rd=5, R reads r_rs=5 with use=1 -> one cycle with e_f=e_r=0, bub_x=1; then all enables 1.
- FORWARDING=0, r_rt=7 matches w_rd=7 with w_we=1 -> stall (bub_x=1). The same stimulus with rd=0 -> no stall.
- x_branch_taken for 1 cycle -> cycle N: bub_r=bub_x=1; cycle N+1: bub_r=1, bub_x=0; cycle N+2: no bubbles. With HAZARD_PERF_EN, perf_flush=1.
- x_branch_taken with m_req=1, m_ready=0 for 3 cycles -> 3 cycles frozen (e_w=1, bub_w=1), then the flush sequence runs exactly once.
- MEM_TIMEOUT=4, m_ready held 0 -> mem_err=1 after the 4th stall edge. It stays 1 after m_ready=1 and clears only on rst.
- rst asserted during FLUSH -> next cycle state RUN with all e_*=0 while rst is high, and the bench sees no stale bub_r after release.
